sub8_44_seq: RTL and testbench

//   Nibble-serial unsigned subtractor: computes {Bout,diff} = A - B - Bin one 4-bit

---
 rtl/sub8_44_pkg.sv | 32 +++
 rtl/sub8_44_seq_sub4.sv | 32 +++
 rtl/sub8_44_seq.sv | 163 ++++++++++++++++
 tb/tb_sub8_44_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sub8_44_pkg.sv
// Shared definitions for the nibble-serial subtractor (sub8_44_seq).
//
// Contents:
//   sub_state_t      : controller state type (IDLE / RUN)
//   ST_IDLE, ST_RUN  : the same encodings as plain logic constants, used for
//                      the state register in the top
//   NIB_DEF          : default slice width processed per clock
//   sub_slice        : reference slice subtract, {b_out, d} = a - b - b_in
package sub8_44_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sub_state_t;

  // Plain-constant view of sub_state_t, for the 1-bit state register.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int NIB_DEF = 4;

  // One-slice subtract at the default slice width. The sub4 slice uses the
  // same arithmetic, widened by one bit so that the borrow lands in the MSB.
  function automatic logic [NIB_DEF:0] sub_slice(
    input logic [NIB_DEF-1:0] a,
    input logic [NIB_DEF-1:0] b,
    input logic               b_in
  );
    sub_slice = {1'b0, a} - {1'b0, b} - {{NIB_DEF{1'b0}}, b_in};
  endfunction

endpackage

// File: rtl/sub8_44_seq_sub4.sv
// sub4: combinational NIB-bit subtract slice with borrow chain.
//
// Computes {b_out, D} = A - B - b_in, all unsigned. The top instantiates it
// once and feeds it a different slice of the captured operands on each pass.
//
// Ports:
//   A     in   NIB  minuend slice
//   B     in   NIB  subtrahend slice
//   b_in  in   1    borrow from the next-lower slice
//   D     out  NIB  difference slice
//   b_out out  1    borrow into the next-higher slice
module sub4
  import sub8_44_pkg::*;
#(
  parameter int NIB = NIB_DEF
) (
  input  logic [NIB-1:0] A,
  input  logic [NIB-1:0] B,
  input  logic           b_in,
  output logic [NIB-1:0] D,
  output logic           b_out
);

  logic [NIB:0] full;

  // The extra top bit goes to 1 exactly when A < B + b_in, which is the
  // borrow out of this slice.
  assign full  = {1'b0, A} - {1'b0, B} - {{NIB{1'b0}}, b_in};
  assign D     = full[NIB-1:0];
  assign b_out = full[NIB];

endmodule

// File: rtl/sub8_44_seq.sv
// sub8_44_seq: nibble-serial unsigned subtractor.
//
// Computes {Bout, diff} = A - B - Bin one NIB-bit slice per clock, LSB slice
// first. The borrow between slices is carried through a register. Operands
// are captured on an accepted start. Results are published all at once on
// the last slice, and they stay unchanged until the next publish.
//
// Handshake: start is sampled on a rising edge only while busy=0. An
// accepted start captures A/B/Bin on that edge. done is a one-cycle pulse
// in the cycle after the edge that publishes diff/Bout/zero. busy drops to 0
// during the final pass, so a start that is held high is taken on the same
// edge that publishes. Back-to-back operations therefore complete once every
// WIDTH/NIB cycles. While busy=1, start and the operand inputs are ignored,
// and no start is queued.
//
// Optional feature (macro SUB8_44_SATURATE_EN): when the result borrows,
// diff is published as 0 and zero as 1. Bout still reports the borrow.
// Without the macro, diff wraps modulo 2^WIDTH.
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of NIB
//   NIB    slice width processed per clock
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst    in   1      synchronous, active-high reset (aborts any operation)
//   start  in   1      operation request
//   A      in   WIDTH  minuend
//   B      in   WIDTH  subtrahend
//   Bin    in   1      borrow-in
//   busy   out  1      operation in progress, further starts not accepted
//   done   out  1      one-cycle pulse: diff/Bout/zero just updated
//   diff   out  WIDTH  registered result
//   Bout   out  1      registered borrow-out
//   zero   out  1      registered diff == 0 flag
module sub8_44_seq
  import sub8_44_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NIB   = NIB_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             Bout,
  output logic             zero
);

  localparam int PASSES = WIDTH / NIB;
  localparam int IDX_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PASSES - 1);

  // Controller state and datapath registers.
  logic [0:0]       state_q;
  logic [IDX_W-1:0] idx_q;
  logic             borrow_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;

  logic             running;
  logic             last_pass;
  logic             accept;

  logic [NIB-1:0]   a_slice;
  logic [NIB-1:0]   b_slice;
  logic [NIB-1:0]   d_slice;
  logic             b_slice_out;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] diff_pub;
  logic             zero_pub;

  assign running   = (state_q == ST_RUN);
  assign last_pass = running && (idx_q == IDX_LAST);
  // busy is already low during the final pass so that a new start can be
  // taken on the publishing edge.
  assign busy      = running && !last_pass;
  assign accept    = start && !busy;

  // Select the slice for the current pass from the captured operands.
  always_comb begin
    a_slice = a_q[int'(idx_q) * NIB +: NIB];
    b_slice = b_q[int'(idx_q) * NIB +: NIB];
  end

  sub4 #(
    .NIB (NIB)
  ) u_sub4 (
    .A     (a_slice),
    .B     (b_slice),
    .b_in  (borrow_q),
    .D     (d_slice),
    .b_out (b_slice_out)
  );

  // The result register with this pass's slice merged in. On the last pass
  // this is the complete difference, and it is published from here.
  always_comb begin
    res_next = res_q;
    res_next[int'(idx_q) * NIB +: NIB] = d_slice;
  end

  // Value and flag to publish. The borrow used is the one out of the final
  // slice, which is the overall borrow.
  always_comb begin
    diff_pub = res_next;
    zero_pub = (res_next == '0);
`ifdef SUB8_44_SATURATE_EN
    if (b_slice_out) begin
      diff_pub = '0;
      zero_pub = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff     <= '0;
      Bout     <= 1'b0;
      zero     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;

      if (running) begin
        res_q    <= res_next;
        borrow_q <= b_slice_out;
        idx_q    <= idx_q + 1'b1;
        if (last_pass) begin
          diff    <= diff_pub;
          Bout    <= b_slice_out;
          zero    <= zero_pub;
          done    <= 1'b1;
          state_q <= ST_IDLE;
        end
      end

      // Placed after the RUN update so that a start accepted on the
      // publishing edge takes priority over the return to IDLE.
      if (accept) begin
        a_q      <= A;
        b_q      <= B;
        borrow_q <= Bin;
        idx_q    <= '0;
        res_q    <= '0;
        state_q  <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_sub8_44_seq.sv
// Directed testbench for sub8_44_seq (default WIDTH=8, NIB=4).
// Inputs are driven on the falling edge. Outputs are sampled 1 ns after the
// rising edge.
module tb_sub8_44_seq;

`ifdef SUB8_44_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       Bout;
  logic       zero;

  int total;
  int passed;
  int fails;

  sub8_44_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .Bout  (Bout),
    .zero  (zero)
  );

  // Clock and global time bound.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  // One complete operation. It issues a start, scrambles the operand inputs
  // while the operation runs, checks the 2-cycle latency and the published
  // result, and then checks that the result holds after done falls.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] exp_diff,
                        input logic exp_bout, input logic exp_zero);
    int lat;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    sample();
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < 8) begin
      sample();
      lat++;
    end
    check({tag, "_lat"},  lat, 32'd2);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_diff"}, {24'd0, diff}, {24'd0, exp_diff});
    check({tag, "_bout"}, {31'd0, Bout}, {31'd0, exp_bout});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
    sample();
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check({tag, "_held"},     {24'd0, diff}, {24'd0, exp_diff});
  endtask

  logic [7:0] exp_done5;
  logic [7:0] exp_busy5;
  int         done_cnt;

  initial begin
    total = 0; passed = 0; fails = 0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (3) sample();

    // Reset values.
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, Bout}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 5A - 23 = 37
    run_op("t1", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
    // Borrow crosses from the low slice into the high slice.
    run_op("t2", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    // Underflow: wraps to FF, or saturates to 0.
    run_op("t3", 8'h00, 8'h01, 1'b0, SAT ? 8'h00 : 8'hFF, 1'b1, SAT);
    // Borrow-in consumes the last unit of difference.
    run_op("t4", 8'h42, 8'h41, 1'b1, 8'h00, 1'b0, 1'b1);
    // A==B with Bin=1: all ones with borrow.
    run_op("t4b", 8'hFF, 8'hFF, 1'b1, SAT ? 8'h00 : 8'hFF, 1'b1, SAT);
    // All ones minus zero.
    run_op("t4c", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);

    // start held high for 6 edges (e1..e6). Completions land on e3, e5, e7.
    // The operands are scrambled between e1 and e2 while busy=1, and that
    // change must be ignored.
    exp_done5 = 8'b0101_0100;  // bit i-1 = expected done after edge e_i
    exp_busy5 = 8'b0001_0101;
    @(negedge clk);
    A = 8'h09; B = 8'h04; Bin = 1'b0; start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      sample();
      check($sformatf("t5_done_e%0d", i), {31'd0, done}, {31'd0, exp_done5[i-1]});
      check($sformatf("t5_busy_e%0d", i), {31'd0, busy}, {31'd0, exp_busy5[i-1]});
      if (exp_done5[i-1])
        check($sformatf("t5_diff_e%0d", i), {24'd0, diff}, 32'h05);
      @(negedge clk);
      if (i == 1) begin A = 8'hFF; B = 8'h00; Bin = 1'b1; end
      if (i == 2) begin A = 8'h09; B = 8'h04; Bin = 1'b0; end
      if (i == 6) start = 1'b0;
    end

    // Reset one cycle after an accepted start aborts the operation.
    A = 8'h5A; B = 8'h23; Bin = 1'b0; start = 1'b1;
    sample();
    check("t6_busy_start", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    sample();
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_done", {31'd0, done}, 32'd0);
    check("t6_diff", {24'd0, diff}, 32'd0);
    check("t6_bout", {31'd0, Bout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (5) begin
      sample();
      if (done === 1'b1) done_cnt++;
    end
    check("t6_no_done", done_cnt, 32'd0);
    check("t6_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
